gfx128_pixel_writer: RTL
========================

Name: gfx128_pixel_writer

Overview:
Render stage directly downstream of the alpha blender. It accepts one finished pixel (x, y, z, 32-bit colour) per handshake and, when enabled, performs a 16-bit depth test against the z-buffer. It then writes the colour, and on pass the new depth, to memory over the 128-bit wishbone-master write and read arbiter ports. It returns a one-cycle ack to the blender when the pixel is retired, whether written or rejected.

Parameters:
point_width, 16, width of pixel_x_i, pixel_y_i, pixel_z_i and target_size_x_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
target_base_i  in  [31:4]  colour surface base, 16-byte word address
zbuffer_base_i  in  [31:4]  z-buffer base, 16-byte word address
target_size_x_i  in  point_width  surface width in pixels
color_depth_i  in  2  00=8bpp, 01=16bpp, 11=32bpp, 10=treated as 32bpp
zbuffer_enable_i  in  1  enable depth test and depth write
pixel_x_i  in  point_width  pixel x
pixel_y_i  in  point_width  pixel y
pixel_z_i  in  point_width signed  pixel depth
pixel_color_i  in  32  colour, right-aligned per depth
write_i  in  1  one-cycle pixel-valid pulse
ack_o  out  1  one-cycle pixel-retired pulse
write_request_o  out  1  write request to wbm writer
write_addr_o  out  [31:4]  write word address
write_data_o  out  128  write data
write_sel_o  out  16  byte enables
write_ack_i  in  1  write done
z_request_o  out  1  depth read request to wbm reader arbiter
z_addr_o  out  [31:4]  depth read word address
z_data_i  in  128  depth read data
z_ack_i  in  1  depth read done

Behaviour:
- Reset (rst_ni low at a clk_i edge) forces state IDLE and drives every output to 0. It also clears all latched pixel registers. Reset mid-operation drops any request immediately and does not pulse ack_o.
- IDLE: write_i is sampled only in IDLE. On write_i, latch x, y, z, colour, depth mode and zbuffer_enable_i. Go to ZREAD if the z-buffer is enabled, else CWRITE. write_i outside IDLE is ignored; the upstream stage issues one pixel per ack.
- Address arithmetic: offset = target_size_x*y + x, 32-bit unsigned.
  - Colour word = target_base + (offset >> s), with s = 4, 3 or 2 for 8, 16 or 32 bpp.
  - Colour lane = offset low bits: [3:0], [2:0] or [1:0].
  - Depth word = zbuffer_base + (offset >> 3). Depth lane = offset[2:0].
  - The address sums wrap modulo 2^28.
- Data formation: write_data_o is the element replicated across 128 bits.
  - Colour element: colour[7:0], [15:0] or [31:0] per depth.
  - Depth element: z replicated 8 times.
  - write_sel_o = 1<<lane, 3<<(2*lane) or F<<(4*lane) for 8, 16 or 32 bpp. The depth write uses 3<<(2*lane).
- ZREAD: z_request_o=1 with z_addr_o stable. On the cycle z_ack_i=1, capture the lane's 16 bits of z_data_i into stored_z. z_request_o=0 from the next cycle. Go to ZTEST.
- ZTEST (1 cycle): pass iff signed pixel_z < signed stored_z. Pass goes to CWRITE; fail goes to DONE with no memory write.
- CWRITE: write_request_o=1 with addr, data and sel stable until write_ack_i is sampled high. Then request=0 from the next cycle. Go to ZWRITE if the z-buffer is enabled, else DONE.
- ZWRITE: same handshake with the depth address, data and sel, then go to DONE.
- DONE: ack_o=1 for exactly one cycle, then IDLE.
- Acks arriving outside the matching request state are ignored.
- An ack may arrive in the first request cycle.
- Minimum latency with no z-buffer and zero-wait ack: write_i at edge 0, request at cycle 1, ack at cycle 1, ack_o at cycle 2, next pixel accepted at cycle 3.

Decomposition:
- The gfx128_pkg additions:
  - color depth constants (CD_8, CD_16, CD_32),
  - the state enum typedef (IDLE, ZREAD, ZTEST, CWRITE, ZWRITE, DONE),
  - a function for lane byte select.
- Sub-module gfx128_pixel_addr (combinational): takes base, size_x, x, y and shift, and returns the word address and lane. It is instantiated twice, once for colour and once for depth.

Test Plan:
- 32bpp, no z-buffer. target_base 0x1000, size_x 640, x=5, y=2, colour 0xAABBCCDD. Required: write_addr 0x1141, sel 0x00F0, data = 0xAABBCCDD x4. ack_o pulses one cycle after write_ack_i.
- 8bpp, x=5, y=0, colour 0x3C. Required: addr 0x1000, sel 0x0020, data = 0x3C x16. A single write occurs; z_request_o never rises.
- Depth pass. zbuffer_base 0x2000, x=5, y=2, z_data lane5 ([95:80]) = 0x0100, pixel_z 0x0080. Required: z_addr 0x20A0. Colour write occurs, then depth write at 0x20A0 with sel 0x0C00 and data 0x0080 x8. Then ack_o.
- Depth fail and signed compare. stored 0x0100 with pixel_z 0x0200: no write_request_o, ack_o two cycles after z_ack_i. Stored 0x0010 with pixel_z 0xFFF0 (-16): must pass.
- Handshake timing. write_ack_i delayed 0, 1 and 7 cycles: request, address and data are held stable throughout. A write_i pulse during a busy state is ignored, and exactly one ack_o occurs per accepted pixel.
- Reset mid-CWRITE. rst_ni low for one cycle: next cycle all outputs are 0 and the state is IDLE with no ack_o. A new pixel is then accepted normally.

Source files
------------

// File: rtl/gfx128_pixel_writer_pkg.sv
// Shared types and helpers for the pixel writer: colour depth codes, FSM states,
// byte-lane select and colour replication.
package gfx128_pixel_writer_pkg;

  localparam logic [1:0] CD_8  = 2'b00;
  localparam logic [1:0] CD_16 = 2'b01;
  localparam logic [1:0] CD_32 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ZREAD  = 3'd1,
    ZTEST  = 3'd2,
    CWRITE = 3'd3,
    ZWRITE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Code 2'b10 is not a real mode and is handled as 32bpp.
  function automatic logic [2:0] cd_shift(input logic [1:0] cd);
    case (cd)
      CD_8:    cd_shift = 3'd4;
      CD_16:   cd_shift = 3'd3;
      CD_32:   cd_shift = 3'd2;
      default: cd_shift = 3'd2;
    endcase
  endfunction

  function automatic logic [15:0] lane_sel(input logic [1:0] cd, input logic [3:0] lane);
    case (cd)
      CD_8:    lane_sel = 16'h0001 << lane;
      CD_16:   lane_sel = 16'h0003 << {lane[2:0], 1'b0};
      default: lane_sel = 16'h000F << {lane[1:0], 2'b00};
    endcase
  endfunction

  function automatic logic [127:0] color_data(input logic [1:0] cd, input logic [31:0] color);
    case (cd)
      CD_8:    color_data = {16{color[7:0]}};
      CD_16:   color_data = {8{color[15:0]}};
      default: color_data = {4{color}};
    endcase
  endfunction

endpackage

// File: rtl/gfx128_pixel_writer_if.sv
// Memory-side bus of the pixel writer: colour/depth write port and depth read port.
interface gfx128_pixel_writer_if;

  logic         write_request_o;
  logic [31:4]  write_addr_o;
  logic [127:0] write_data_o;
  logic [15:0]  write_sel_o;
  logic         write_ack_i;
  logic         z_request_o;
  logic [31:4]  z_addr_o;
  logic [127:0] z_data_i;
  logic         z_ack_i;

  modport master (
    output write_request_o, write_addr_o, write_data_o, write_sel_o, z_request_o, z_addr_o,
    input  write_ack_i, z_data_i, z_ack_i
  );

  modport slave (
    input  write_request_o, write_addr_o, write_data_o, write_sel_o, z_request_o, z_addr_o,
    output write_ack_i, z_data_i, z_ack_i
  );

endinterface

// File: rtl/gfx128_pixel_writer_addr.sv
// Pixel to 16-byte word address translation: word = base + (y*size_x + x) >> shift,
// lane = the offset bits dropped by the shift.
module gfx128_pixel_addr #(
  parameter int point_width = 16
) (
  input  logic [31:4]            i_base,
  input  logic [point_width-1:0] i_size_x,
  input  logic [point_width-1:0] i_x,
  input  logic [point_width-1:0] i_y,
  input  logic [2:0]             i_shift,
  output logic [31:4]            o_word,
  output logic [3:0]             o_lane
);

  logic [31:0] w_offset;
  logic [27:0] w_shifted;
  logic [3:0]  w_mask;

  always_comb begin
    w_offset  = 32'(i_size_x) * 32'(i_y) + 32'(i_x);
    w_shifted = 28'(w_offset >> i_shift);
    w_mask    = 4'((5'd1 << i_shift) - 5'd1);
    o_word    = i_base + w_shifted;
    o_lane    = w_offset[3:0] & w_mask;
  end

endmodule

// File: rtl/gfx128_pixel_writer.sv
// Pixel writer: optional 16-bit depth test, then colour write and depth write over
// the 128-bit memory ports; one-cycle ack_o per retired pixel.
module gfx128_pixel_writer
  import gfx128_pixel_writer_pkg::*;
#(
  parameter int point_width = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [31:4]                   target_base_i,
  input  logic [31:4]                   zbuffer_base_i,
  input  logic [point_width-1:0]        target_size_x_i,
  input  logic [1:0]                    color_depth_i,
  input  logic                          zbuffer_enable_i,
  input  logic [point_width-1:0]        pixel_x_i,
  input  logic [point_width-1:0]        pixel_y_i,
  input  logic signed [point_width-1:0] pixel_z_i,
  input  logic [31:0]                   pixel_color_i,
  input  logic                          write_i,
  output logic                          ack_o,
  gfx128_pixel_writer_if.master         bus
);

  state_t                  r_state, w_state_next;
  logic [point_width-1:0]  r_x, r_y, w_x, w_y;
  logic [point_width-1:0]  r_z, w_z;
  logic [31:0]             r_color, w_color;
  logic [1:0]              r_cd, w_cd;
  logic                    r_zen, w_zen;
  logic [15:0]             r_stored_z, w_z16;
  logic                    w_z_pass;
  logic [31:4]             w_color_word, w_z_word;
  logic [3:0]              w_color_lane, w_z_lane;

  logic         r_write_request, w_write_request;
  logic [31:4]  r_write_addr, w_write_addr;
  logic [127:0] r_write_data, w_write_data;
  logic [15:0]  r_write_sel, w_write_sel;
  logic         r_z_request, w_z_request;
  logic [31:4]  r_z_addr, w_z_addr;
  logic         r_ack, w_ack;

  // Addresses are formed from the next-cycle pixel fields so outputs can be registered.
  gfx128_pixel_addr #(.point_width(point_width)) u_color_addr (
    .i_base(target_base_i), .i_size_x(target_size_x_i), .i_x(w_x), .i_y(w_y),
    .i_shift(cd_shift(w_cd)), .o_word(w_color_word), .o_lane(w_color_lane)
  );

  gfx128_pixel_addr #(.point_width(point_width)) u_depth_addr (
    .i_base(zbuffer_base_i), .i_size_x(target_size_x_i), .i_x(w_x), .i_y(w_y),
    .i_shift(3'd3), .o_word(w_z_word), .o_lane(w_z_lane)
  );

  always_comb begin
    w_state_next = r_state;
    w_x = r_x; w_y = r_y; w_z = r_z; w_color = r_color; w_cd = r_cd; w_zen = r_zen;
    w_z16    = 16'(w_z);
    w_z_pass = $signed(16'(r_z)) < $signed(r_stored_z);
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_x = pixel_x_i; w_y = pixel_y_i; w_z = pixel_z_i; w_color = pixel_color_i;
          w_cd = color_depth_i; w_zen = zbuffer_enable_i;
          w_z16 = 16'(pixel_z_i);
          w_state_next = zbuffer_enable_i ? ZREAD : CWRITE;
        end else begin
          w_state_next = IDLE;
        end
      end
      ZREAD:  w_state_next = bus.z_ack_i ? ZTEST : ZREAD;
      ZTEST:  w_state_next = w_z_pass ? CWRITE : DONE;
      CWRITE: begin
        if (bus.write_ack_i) begin
          w_state_next = r_zen ? ZWRITE : DONE;
        end else begin
          w_state_next = CWRITE;
        end
      end
      ZWRITE: w_state_next = bus.write_ack_i ? DONE : ZWRITE;
      DONE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    w_write_request = 1'b0; w_write_addr = 28'h0; w_write_data = 128'h0; w_write_sel = 16'h0;
    w_z_request = 1'b0; w_z_addr = 28'h0; w_ack = 1'b0;
    case (w_state_next)
      ZREAD: begin
        w_z_request = 1'b1;
        w_z_addr    = w_z_word;
      end
      CWRITE: begin
        w_write_request = 1'b1;
        w_write_addr    = w_color_word;
        w_write_data    = color_data(w_cd, w_color);
        w_write_sel     = lane_sel(w_cd, w_color_lane);
      end
      ZWRITE: begin
        w_write_request = 1'b1;
        w_write_addr    = w_z_word;
        w_write_data    = {8{w_z16}};
        w_write_sel     = lane_sel(CD_16, w_z_lane);
      end
      DONE:    w_ack = 1'b1;
      default: w_ack = 1'b0;
    endcase
  end

  // State, latched pixel, captured depth and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_x <= '0; r_y <= '0; r_z <= '0; r_color <= 32'h0; r_cd <= 2'b00; r_zen <= 1'b0;
      r_stored_z <= 16'h0;
      r_write_request <= 1'b0; r_write_addr <= 28'h0; r_write_data <= 128'h0;
      r_write_sel <= 16'h0; r_z_request <= 1'b0; r_z_addr <= 28'h0; r_ack <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x <= w_x; r_y <= w_y; r_z <= w_z; r_color <= w_color; r_cd <= w_cd; r_zen <= w_zen;
      if (r_state == ZREAD && bus.z_ack_i) begin
        r_stored_z <= bus.z_data_i[{w_z_lane[2:0], 4'b0000} +: 16];
      end
      r_write_request <= w_write_request; r_write_addr <= w_write_addr;
      r_write_data <= w_write_data; r_write_sel <= w_write_sel;
      r_z_request <= w_z_request; r_z_addr <= w_z_addr; r_ack <= w_ack;
    end
  end

  assign bus.write_request_o = r_write_request;
  assign bus.write_addr_o    = r_write_addr;
  assign bus.write_data_o    = r_write_data;
  assign bus.write_sel_o     = r_write_sel;
  assign bus.z_request_o     = r_z_request;
  assign bus.z_addr_o        = r_z_addr;
  assign ack_o               = r_ack;

endmodule
